// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state encoding plus the fill/step constants.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDrop
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_buffer.sv
// Small circular FIFO of {addr, instr} pairs between instruction memory and IF/ID.
// Clear takes priority over push/pop so a redirect always leaves the buffer empty.
module fetch_buffer #(
  parameter int unsigned Depth = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        clear_i,
  input  logic [31:0] push_addr_i,
  input  logic [31:0] push_instr_i,
  output logic [31:0] head_addr_o,
  output logic [31:0] head_instr_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [31:0]     addr_q  [Depth];
  logic [31:0]     instr_q [Depth];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign full_o       = (count_q == CntW'(Depth));
  assign empty_o      = (count_q == '0);
  assign do_push      = push_i & ~full_o;
  assign do_pop       = pop_i & ~empty_o;
  assign head_addr_o  = addr_q[rd_ptr_q];
  assign head_instr_o = instr_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        addr_q[i]  <= '0;
        instr_q[i] <= '0;
      end
    end else if (clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        addr_q[wr_ptr_q]  <= push_addr_i;
        instr_q[wr_ptr_q] <= push_instr_i;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one outstanding memory read at a time feeding a small buffer.
// Taken branches flush the buffer; an in-flight read is either dropped on ack or discarded.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        hazardDetected_i,
  input  logic        branch_i,
  input  logic [31:0] branchTarget_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] instrAddr_o,
  output logic        valid_o,
  output logic        IFFlush_o
);

  fetch_state_e state_q;
  logic [31:0]  fetch_pc_q;
  logic         req_q;
  logic [31:0]  req_addr_q;

  logic        redirect, push, pop;
  logic        buf_full, buf_empty;
  logic [31:0] head_addr, head_instr;
  logic [31:0] redirect_pc;
  logic        unused_tgt_bits;

  assign redirect_pc     = {branchTarget_i[31:2], 2'b00};
  assign unused_tgt_bits = ^branchTarget_i[1:0];

  // Gated by reset so the flush pulse stays low while the unit is held in reset.
  assign redirect  = branch_i & ~stall_i & rst_i;
  assign pop       = ~buf_empty & ~stall_i & ~hazardDetected_i & ~branch_i;
  assign push      = (state_q == StWait) & imem_ack_i & ~redirect;

  assign IFFlush_o   = redirect;
  assign imem_req_o  = req_q;
  assign imem_addr_o = req_addr_q;
  assign valid_o     = ~buf_empty;
  assign instr_o     = buf_empty ? NOP_INSTR : head_instr;
  assign instrAddr_o = buf_empty ? 32'h0 : head_addr;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      req_addr_q <= '0;
    end else begin
      if (redirect) begin
        fetch_pc_q <= redirect_pc;
      end
      unique case (state_q)
        StIdle: begin
          // Count only includes buffered entries; nothing is in flight in idle.
          if (!redirect && !buf_full) begin
            req_q      <= 1'b1;
            req_addr_q <= fetch_pc_q;
            fetch_pc_q <= fetch_pc_q + PC_STEP;
            state_q    <= StWait;
          end
        end
        StWait: begin
          if (imem_ack_i) begin
            req_q   <= 1'b0;
            state_q <= StIdle;
          end else if (redirect) begin
            state_q <= StDrop;
          end
        end
        StDrop: begin
          if (imem_ack_i) begin
            req_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  fetch_buffer #(
    .Depth (BUF_DEPTH)
  ) u_fetch_buffer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (push),
    .pop_i        (pop),
    .clear_i      (redirect),
    .push_addr_i  (req_addr_q),
    .push_instr_i (imem_rdata_i),
    .head_addr_o  (head_addr),
    .head_instr_o (head_instr),
    .full_o       (buf_full),
    .empty_o      (buf_empty)
  );

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 Parameter BUF_DEPTH, default 2, number of fetch-buffer entries; the legal range is 2..4.
REQ-003 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous assertion, active-low.
REQ-005 stall_i  input  1  global pipeline stall; freezes the consumer side.
REQ-006 hazardDetected_i  input  1  ID-stage load-use hazard; holds the current output instruction.
REQ-007 branch_i  input  1  taken branch or jump resolved in ID; requests a redirect.
REQ-008 branchTarget_i  input  32  redirect address; bits [1:0] ignored and treated as 0.
REQ-009 imem_req_o  output  1  instruction-memory read request.
REQ-010 imem_addr_o  output  32  request address; word-aligned.
REQ-011 imem_ack_i  input  1  one-cycle pulse; read data valid this cycle.
REQ-012 imem_rdata_i  input  32  read data, sampled only when imem_ack_i=1.
REQ-013 instr_o  output  32  instruction presented to the IF/ID register.
REQ-014 instrAddr_o  output  32  address of instr_o.
REQ-015 valid_o  output  1  instr_o/instrAddr_o hold a real fetched instruction.
REQ-016 IFFlush_o  output  1  flush pulse to the IF/ID register.

Function
REQ-017 The FSM SHALL have exactly three states, IDLE, WAIT and DROP, with at most one memory request outstanding.
REQ-018 In IDLE with (buffer count + 0) < BUF_DEPTH, the unit SHALL assert imem_req_o with imem_addr_o=fetch_pc, advance fetch_pc by 4 (32-bit modulo) and enter WAIT.
REQ-019 In WAIT, imem_req_o and imem_addr_o SHALL be held stable until imem_ack_i; ack may arrive at the earliest 1 cycle after the request.
REQ-020 On an ack in WAIT, the unit SHALL push {request address, imem_rdata_i} into the buffer and return to IDLE; the next request may issue the following cycle.
REQ-021 valid_o SHALL equal buffer-not-empty; instr_o/instrAddr_o SHALL show the buffer head, or 32'h0/32'h0 when empty.
REQ-022 The head SHALL be popped on a cycle when valid_o=1, stall_i=0, hazardDetected_i=0 and branch_i=0.
REQ-023 A redirect SHALL be accepted when branch_i=1 and stall_i=0; branch_i while stall_i=1 SHALL be ignored.
REQ-024 An accepted redirect SHALL have the following effects: IFFlush_o=1 combinationally in that cycle; buffer emptied; fetch_pc <= {branchTarget_i[31:2],2'b00}.
REQ-025 On a redirect in WAIT without ack, the FSM SHALL enter DROP; in DROP the old request stays asserted until ack, its data is discarded, and the FSM returns to IDLE.
REQ-026 If a redirect and an ack occur in the same WAIT cycle, the ack data SHALL be discarded and the FSM SHALL go to IDLE, not DROP.
REQ-027 Simultaneous push and pop SHALL leave the count unchanged; a push when full SHALL never occur, by construction of REQ-018.
REQ-028 stall_i SHALL NOT block the memory side: requests and pushes continue until the buffer is full.
REQ-029 IFFlush_o SHALL be 0 in every cycle without an accepted redirect.

Reset
REQ-030 When rst_i=0, all state SHALL clear asynchronously: FSM=IDLE, fetch_pc=RESET_PC, buffer empty, imem_req_o=0, valid_o=0, instr_o=0, instrAddr_o=0, IFFlush_o=0.
REQ-031 The first request SHALL assert in the first rising edge's cycle after rst_i rises, with address RESET_PC.
REQ-032 A reset during WAIT or DROP SHALL abandon the outstanding request; a late ack after reset SHALL be ignored while the FSM is in IDLE.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the NOP_INSTR constant (32'h0) and the PC_STEP constant (4).
REQ-034 The buffer SHALL be a sub-module fetch_buffer, a BUF_DEPTH-entry FIFO of {addr[31:0], instr[31:0]} with push, pop, clear, full and empty.

Verification
REQ-035 Reset sequence: reset release, then ack each request after 1 cycle with rdata=addr^32'hA5A5A5A5 -> requests to 0x0, 0x4, 0x8; valid_o outputs in address order.
REQ-036 stall_i=1 for 10 cycles -> exactly BUF_DEPTH pushes, then imem_req_o stays 0; head is held; draining resumes on release without loss.
REQ-037 branch_i=1 with target 0x103 while in WAIT and ack delayed 3 cycles -> one-cycle IFFlush_o pulse; stale data is dropped; the next request goes to 0x100.
REQ-038 branch_i with ack in the same cycle -> ack data never appears on instr_o; the next request goes to the target.
REQ-039 hazardDetected_i=1 for 2 cycles -> instr_o/instrAddr_o are unchanged; no pop occurs.
REQ-040 fetch_pc=32'hFFFF_FFFC -> the next request is to 32'h0000_0000; also, asserting rst_i in DROP -> all outputs are 0 immediately.
